// File: rtl/fl_multi.sv
// N-way rename free list: a ring of free physical tags with zero-latency allocation and WAYS-wide retire write-back.
// Latency: tags and grant are combinational from registered state; there is no backpressure beyond grant clamping and fl_stall.
module fl_multi #(
  parameter int WAYS      = 2,
  parameter int PREG_W    = 7,
  parameter int ARCH_REGS = 32,
  parameter int DEPTH     = 64,
  localparam int AW       = $clog2(DEPTH),
  localparam int NW       = $clog2(WAYS) + 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NW-1:0]            id_dispatch_req,
  output logic [NW-1:0]            fl_dispatch_grant,
  output logic [WAYS*PREG_W-1:0]   fl_pr,
  output logic [WAYS-1:0]          fl_pr_valid,
  input  logic [NW-1:0]            rob_retire_num,
  input  logic [WAYS*PREG_W-1:0]   rob_retire_tags,
  input  logic                     recover,
  output logic [AW:0]              fl_free_count,
  output logic                     fl_stall,
  output logic                     fl_err_underflow
);

  logic [PREG_W-1:0] fl_buf [DEPTH];
  logic [AW-1:0]     alloc_ptr;
  logic [AW-1:0]     rel_ptr;
  logic [AW:0]       inflight;

  logic [NW-1:0]     req_clamp;
  logic [NW-1:0]     ret_clamp;
  logic [NW-1:0]     eff_ret;
  logic              underflow;

  assign fl_free_count = (AW+1)'(DEPTH) - inflight;
  assign fl_stall      = fl_free_count < (AW+1)'(WAYS);

  // Any clamped value that falls back to a count is below WAYS, so the low NW bits are exact.
  always_comb begin
    req_clamp = (id_dispatch_req > NW'(WAYS)) ? NW'(WAYS) : id_dispatch_req;
    ret_clamp = (rob_retire_num  > NW'(WAYS)) ? NW'(WAYS) : rob_retire_num;

    fl_dispatch_grant = '0;
    if (!recover) begin
      if ((AW+1)'(req_clamp) <= fl_free_count) begin
        fl_dispatch_grant = req_clamp;
      end else begin
        fl_dispatch_grant = fl_free_count[NW-1:0];
      end
    end

    eff_ret   = ((AW+1)'(ret_clamp) <= inflight) ? ret_clamp : inflight[NW-1:0];
    underflow = (AW+1)'(rob_retire_num) > inflight;
  end

  always_comb begin
    fl_pr       = '0;
    fl_pr_valid = '0;
    for (int k = 0; k < WAYS; k++) begin
      fl_pr[k*PREG_W +: PREG_W] = fl_buf[alloc_ptr + AW'(k)];
      fl_pr_valid[k]            = (AW+1)'(k) < fl_free_count;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        fl_buf[i] <= PREG_W'(ARCH_REGS + i);
      end
      alloc_ptr        <= '0;
      rel_ptr          <= '0;
      inflight         <= '0;
      fl_err_underflow <= 1'b0;
    end else begin
      for (int k = 0; k < WAYS; k++) begin
        if (NW'(k) < eff_ret) begin
          fl_buf[rel_ptr + AW'(k)] <= rob_retire_tags[k*PREG_W +: PREG_W];
        end
      end
      rel_ptr <= rel_ptr + AW'(eff_ret);
      // On a mispredict every unretired tag becomes free again, starting just past this cycle's retires.
      if (recover) begin
        alloc_ptr <= rel_ptr + AW'(eff_ret);
        inflight  <= '0;
      end else begin
        alloc_ptr <= alloc_ptr + AW'(fl_dispatch_grant);
        inflight  <= inflight + (AW+1)'(fl_dispatch_grant) - (AW+1)'(eff_ret);
      end
      if (underflow) begin
        fl_err_underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fl_multi.sv
// Random plus directed bench for fl_multi; a free-queue / in-flight-queue model feeds a scoreboard checked at negedge.
module tb_fl_multi;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  id_dispatch_req = '0;
  logic [1:0]  fl_dispatch_grant;
  logic [13:0] fl_pr;
  logic [1:0]  fl_pr_valid;
  logic [1:0]  rob_retire_num = '0;
  logic [13:0] rob_retire_tags = '0;
  logic        recover = 1'b0;
  logic [6:0]  fl_free_count;
  logic        fl_stall;
  logic        fl_err_underflow;

  always #5 clock = ~clock;

  fl_multi #(.WAYS(2), .PREG_W(7), .ARCH_REGS(32), .DEPTH(64)) dut (
    .clock             (clock),
    .reset             (reset),
    .id_dispatch_req   (id_dispatch_req),
    .fl_dispatch_grant (fl_dispatch_grant),
    .fl_pr             (fl_pr),
    .fl_pr_valid       (fl_pr_valid),
    .rob_retire_num    (rob_retire_num),
    .rob_retire_tags   (rob_retire_tags),
    .recover           (recover),
    .fl_free_count     (fl_free_count),
    .fl_stall          (fl_stall),
    .fl_err_underflow  (fl_err_underflow)
  );

  typedef struct {
    logic [1:0]      grant;
    logic [1:0][6:0] pr;
    logic [1:0]      vld;
    logic [6:0]      fc;
    logic            stall;
    logic            err;
    string           tag;
  } exp_t;

  exp_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int unsigned free_q[$];
  int unsigned spec_q[$];
  bit          m_err;

  function automatic int min3(int a, int b, int c);
    int m;
    m = a;
    if (b < m) m = b;
    if (c < m) m = c;
    return m;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, expv);
    end
  endtask

  function automatic void model_reset();
    free_q.delete();
    spec_q.delete();
    for (int i = 0; i < 64; i++) free_q.push_back(32 + i);
    m_err = 1'b0;
  endfunction

  // Dispatch takes from the head of the free queue; retire appends freed tags to its tail;
  // recover returns the still-speculative tags, in dispatch order, to the head.
  function automatic void model_step(int g, int num, logic [13:0] tags, bit rec);
    int pre;
    int eff;
    pre = spec_q.size();
    eff = min3(num, 2, pre);
    for (int i = 0; i < g; i++) spec_q.push_back(free_q.pop_front());
    for (int i = 0; i < eff; i++) void'(spec_q.pop_front());
    for (int i = 0; i < eff; i++) free_q.push_back(32'(tags[i*7 +: 7]));
    if (rec) begin
      free_q = {spec_q, free_q};
      spec_q.delete();
    end
    if (num > pre) m_err = 1'b1;
  endfunction

  task automatic cycle(input int req, input int num, input logic [13:0] tags,
                       input bit rec, input bit rst_v, input string ph);
    exp_t e;
    int   fsz;
    int   g;
    @(posedge clock);
    #1;
    reset = rst_v;
    if (!rst_v) model_reset();
    id_dispatch_req = 2'(req);
    rob_retire_num  = 2'(num);
    rob_retire_tags = tags;
    recover         = rec;
    fsz = free_q.size();
    g   = rec ? 0 : min3(req, 2, fsz);
    e.grant = 2'(g);
    for (int k = 0; k < 2; k++) begin
      e.vld[k] = (k < fsz);
      e.pr[k]  = (k < fsz) ? 7'(free_q[k]) : 7'd0;
    end
    e.fc    = 7'(fsz);
    e.stall = (fsz < 2);
    e.err   = m_err;
    e.tag   = ph;
    exp_q.push_back(e);
    if (rst_v) model_step(g, num, tags, rec);
  endtask

  function automatic logic [13:0] spec_tags();
    logic [13:0] t;
    for (int k = 0; k < 2; k++) begin
      t[k*7 +: 7] = (k < spec_q.size()) ? 7'(spec_q[k]) : 7'($urandom_range(0, 127));
    end
    return t;
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk({e.tag, ".grant"}, 32'(fl_dispatch_grant), 32'(e.grant));
        chk({e.tag, ".valid"}, 32'(fl_pr_valid), 32'(e.vld));
        chk({e.tag, ".free_count"}, 32'(fl_free_count), 32'(e.fc));
        chk({e.tag, ".stall"}, 32'(fl_stall), 32'(e.stall));
        chk({e.tag, ".err"}, 32'(fl_err_underflow), 32'(e.err));
        for (int k = 0; k < 2; k++) begin
          if (e.vld[k]) chk($sformatf("%s.slot%0d", e.tag, k), 32'(fl_pr[k*7 +: 7]), 32'(e.pr[k]));
        end
        chk({e.tag, ".no_overlap"}, 32'(7'(fl_dispatch_grant) <= fl_free_count), 32'd1);
      end
    end
  end

  initial begin : driver
    int req;
    int num;
    bit rec;
    bit rst_v;
    model_reset();

    // Reset state, then idle.
    cycle(0, 0, '0, 0, 0, "reset");
    cycle(0, 0, '0, 0, 1, "idle");
    cycle(0, 0, '0, 0, 1, "idle2");

    // Drain the whole list two at a time, then ask for more.
    repeat (32) cycle(2, 0, '0, 0, 1, "fill");
    cycle(2, 0, '0, 0, 1, "empty");
    cycle(0, 0, '0, 0, 1, "empty_idle");

    // One tag left: request two.
    cycle(0, 0, '0, 0, 0, "rst_b");
    repeat (31) cycle(2, 0, '0, 0, 1, "fill_b");
    cycle(1, 0, '0, 0, 1, "fill_b1");
    cycle(2, 0, '0, 0, 1, "one_left");
    cycle(0, 0, '0, 0, 1, "now_empty");

    // Wrap-around of the allocation pointer onto freshly retired tags.
    cycle(0, 0, '0, 0, 0, "rst_c");
    repeat (31) cycle(2, 0, '0, 0, 1, "fill_c");
    cycle(1, 0, '0, 0, 1, "fill_c1");
    cycle(0, 2, {7'd41, 7'd40}, 0, 1, "ret_40_41");
    cycle(1, 0, '0, 0, 1, "take_95");
    cycle(0, 0, '0, 0, 1, "wrap");

    // Mispredict with a same-cycle retire.
    cycle(0, 0, '0, 0, 0, "rst_d");
    repeat (5) cycle(2, 0, '0, 0, 1, "fill_d");
    cycle(2, 2, spec_tags(), 1, 1, "recover");
    cycle(0, 0, '0, 0, 1, "post_recover");
    cycle(2, 0, '0, 0, 1, "post_recover2");

    // Underflow, stickiness, then asynchronous clear mid-cycle.
    cycle(0, 0, '0, 0, 0, "rst_e");
    cycle(1, 0, '0, 0, 1, "one_out");
    cycle(0, 2, {7'd99, 7'd50}, 0, 1, "underflow");
    cycle(0, 0, '0, 0, 1, "err_set");
    cycle(2, 1, spec_tags(), 0, 1, "err_sticky");
    cycle(0, 0, '0, 0, 0, "mid_reset");
    cycle(0, 0, '0, 0, 1, "after_reset");

    // Randomised traffic with occasional recover, overdrawn retire and mid-run reset.
    for (int i = 0; i < 3000; i++) begin
      req = $urandom_range(0, 3);
      num = $urandom_range(0, 3);
      if (((i / 200) % 2) == 1) num = num / 2;
      if ($urandom_range(0, 7) != 0 && num > spec_q.size()) num = spec_q.size();
      rec   = ($urandom_range(0, 39) == 0);
      rst_v = ($urandom_range(0, 499) != 0);
      cycle(req, num, spec_tags(), rec, rst_v, "rand");
    end

    @(posedge clock);
    #1;
    id_dispatch_req = '0;
    rob_retire_num  = '0;
    recover         = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    chk("drain", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
